// File: rtl/spi_word_arbiter.sv
// spi_word_arbiter
// Two-requester SPI master for the configuration bus. A round-robin arbiter
// chooses one requester. The chosen 16-bit word is then shifted out MSB
// first, in SPI mode 0. A clock-enable divider makes SCLK from the system
// clock, so there is only one clock domain.
//
// Ports:
//   clock     system clock
//   reset     asynchronous, active-high reset
//   req0/1    transfer request; held high until the matching ack
//   data0/1   16-bit word; captured when its request is granted
//   ack0/1    one-cycle pulse after the granted word has been fully sent
//   busy      high whenever the engine is not idle
//   spi_cs_n  chip select, active low
//   spi_sclk  SPI clock, idles low
//   spi_mosi  serial data, MSB first
//
// All outputs are registered. They are decoded from the next-state values,
// so each output changes on the same edge as the state it belongs to.

module spi_word_arbiter #(
   parameter int unsigned CLK_DIV = 20
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0,
   input  logic [15:0] data0,
   output logic        ack0,
   input  logic        req1,
   input  logic [15:0] data1,
   output logic        ack1,
   output logic        busy,
   output logic        spi_cs_n,
   output logic        spi_sclk,
   output logic        spi_mosi
);

   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] DIV_ONE  = CW'(1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP,
      DONE
   } state_t;

   state_t        state, state_next;
   logic [CW-1:0] div_cnt, div_next;
   logic [3:0]    bit_cnt, bit_next;
   logic          phase, phase_next;
   logic [15:0]   shift_reg, shift_next;
   logic          grant, grant_next;
   logic          last_grant, last_grant_next;
   logic          tick;
   logic          cs_active_next;

   // The half-period tick marks the last cycle of each CLK_DIV-long slice.
   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         phase      <= 1'b0;
         shift_reg  <= '0;
         grant      <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         state      <= state_next;
         div_cnt    <= div_next;
         bit_cnt    <= bit_next;
         phase      <= phase_next;
         shift_reg  <= shift_next;
         grant      <= grant_next;
         last_grant <= last_grant_next;
      end
   end

   // In SHIFT, phase is the SCLK level of the current half-bit.
   // In GAP, phase tells which of the two half-periods is running.
   // The divider restarts from zero on every state entry and every tick.
   always_comb begin
      state_next      = state;
      div_next        = div_cnt + DIV_ONE;
      bit_next        = bit_cnt;
      phase_next      = phase;
      shift_next      = shift_reg;
      grant_next      = grant;
      last_grant_next = last_grant;

      case (state)
         IDLE: begin
            div_next = '0;
            if (req0 || req1) begin
               // On a tie, the requester that was not served last time wins.
               if (req0 && req1) begin
                  grant_next = ~last_grant;
               end else begin
                  grant_next = req1;
               end
               last_grant_next = grant_next;
               shift_next      = grant_next ? data1 : data0;
               phase_next      = 1'b0;
               state_next      = SETUP;
            end
         end

         SETUP: begin
            if (tick) begin
               div_next   = '0;
               phase_next = 1'b0;
               bit_next   = 4'd15;
               state_next = SHIFT;
            end
         end

         SHIFT: begin
            if (tick) begin
               div_next = '0;
               if (!phase) begin
                  phase_next = 1'b1;
               end else if (bit_cnt == 4'd0) begin
                  // Stop without shifting, so bit 0 stays on MOSI during HOLD.
                  phase_next = 1'b0;
                  state_next = HOLD;
               end else begin
                  phase_next = 1'b0;
                  bit_next   = bit_cnt - 4'd1;
                  shift_next = {shift_reg[14:0], 1'b0};
               end
            end
         end

         HOLD: begin
            if (tick) begin
               div_next   = '0;
               phase_next = 1'b0;
               state_next = GAP;
            end
         end

         GAP: begin
            if (tick) begin
               div_next = '0;
               if (!phase) begin
                  phase_next = 1'b1;
               end else begin
                  phase_next = 1'b0;
                  state_next = DONE;
               end
            end
         end

         DONE: begin
            div_next   = '0;
            state_next = IDLE;
         end

         default: begin
            div_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

   assign cs_active_next = (state_next == SETUP) || (state_next == SHIFT) ||
                           (state_next == HOLD);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         spi_cs_n <= 1'b1;
         spi_sclk <= 1'b0;
         spi_mosi <= 1'b0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         spi_cs_n <= ~cs_active_next;
         spi_sclk <= (state_next == SHIFT) && phase_next;
         spi_mosi <= cs_active_next && shift_next[15];
         ack0     <= (state_next == DONE) && !grant_next;
         ack1     <= (state_next == DONE) && grant_next;
         busy     <= (state_next != IDLE);
      end
   end

endmodule

// File: tb/tb_spi_word_arbiter.sv
// tb_spi_word_arbiter
// Self-checking bench for spi_word_arbiter. The main instance uses
// CLK_DIV=4. A second instance uses CLK_DIV=20 and is only used to check
// the SCLK rate. A transaction-level model gives the expected output value
// for every cycle. It works from the time offset since the grant, so it does
// not copy the design's state machine. Directed checks then compare the
// words captured from MOSI against literal expected values.

module tb_spi_word_arbiter;

   localparam int D = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [15:0] data0 = '0, data1 = '0;
   logic        ack0, ack1, busy, spi_cs_n, spi_sclk, spi_mosi;

   logic        r20a = 1'b0, r20b = 1'b0;
   logic [15:0] d20a = '0, d20b = '0;
   logic        a20a, a20b, busy20, cs20, sclk20, mosi20;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   spi_word_arbiter #(.CLK_DIV(D)) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .data0(data0), .ack0(ack0),
      .req1(req1), .data1(data1), .ack1(ack1),
      .busy(busy), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi)
   );

   spi_word_arbiter #(.CLK_DIV(20)) dut20 (
      .clock(clock), .reset(reset),
      .req0(r20a), .data0(d20a), .ack0(a20a),
      .req1(r20b), .data1(d20b), .ack1(a20b),
      .busy(busy20), .spi_cs_n(cs20), .spi_sclk(sclk20), .spi_mosi(mosi20)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
      end
   endtask

   task automatic checkBit(input string name, input logic actual, input logic required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s actual=%b required=%b at %0t", name, actual, required, $time);
      end
   endtask

   task automatic applyStimulus(input logic r0, input logic [15:0] d0, input logic r1, input logic [15:0] d1);
      req0  = r0;
      data0 = d0;
      req1  = r1;
      data1 = d1;
   endtask

   // Transaction-level model. Time is counted in cycles since the grant
   // edge; t=1 is the first cycle with chip select low.
   bit          m_act = 1'b0;
   int          m_t = 0;
   logic [15:0] m_w = '0;
   bit          m_g = 1'b0;
   bit          m_lg = 1'b1;

   function automatic bit pick(input logic r0, input logic r1, input bit lg);
      if (r0 && r1) return !lg;
      return r1;
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_act <= 1'b0;
         m_t   <= 0;
         m_lg  <= 1'b1;
         m_g   <= 1'b0;
      end else if (m_act) begin
         m_t <= m_t + 1;
         if (m_t + 1 == 36 * D + 2) m_act <= 1'b0;
      end else if (req0 || req1) begin
         m_g   <= pick(req0, req1, m_lg);
         m_lg  <= pick(req0, req1, m_lg);
         m_w   <= pick(req0, req1, m_lg) ? data1 : data0;
         m_act <= 1'b1;
         m_t   <= 1;
      end
   end

   // Returns {cs_n, sclk, mosi, ack0, ack1, busy} for offset t.
   function automatic logic [5:0] expected(input bit act, input int t, input logic [15:0] w, input bit g);
      logic cs_n, sclk, mosi, a0, a1, b;
      int   u, bit_idx;
      cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; a0 = 1'b0; a1 = 1'b0; b = 1'b0;
      if (act) begin
         b = 1'b1;
         if (t <= 34 * D) cs_n = 1'b0;
         if (t <= D) begin
            mosi = w[15];
         end else if (t <= 33 * D) begin
            u       = t - 1 - D;
            bit_idx = u / (2 * D);
            sclk    = (u % (2 * D)) >= D;
            mosi    = w[15 - bit_idx];
         end else if (t <= 34 * D) begin
            mosi = w[0];
         end
         if (t == 36 * D + 1) begin
            a0 = !g;
            a1 = g;
         end
      end
      return {cs_n, sclk, mosi, a0, a1, b};
   endfunction

   logic [5:0] exp_vec;
   assign exp_vec = expected(m_act, m_t, m_w, m_g);

   always @(negedge clock) begin
      checkBit("cyc_cs_n", spi_cs_n, exp_vec[5]);
      checkBit("cyc_sclk", spi_sclk, exp_vec[4]);
      checkBit("cyc_mosi", spi_mosi, exp_vec[3]);
      checkBit("cyc_ack0", ack0, exp_vec[2]);
      checkBit("cyc_ack1", ack1, exp_vec[1]);
      checkBit("cyc_busy", busy, exp_vec[0]);
   end

   // Bus monitor: collects the word seen on MOSI at SCLK rising edges and
   // measures how long chip select stays high between words.
   logic [15:0] cap = '0;
   int          rises = 0;
   logic        prev_sclk = 1'b0, prev_cs = 1'b1;
   int          hi_len = 0, last_hi_len = 0;
   int          ack_cnt0 = 0, ack_cnt1 = 0;
   logic [15:0] rx[$];

   always @(negedge clock) begin
      if (reset) begin
         cap       <= '0;
         rises     <= 0;
         prev_sclk <= 1'b0;
         prev_cs   <= 1'b1;
         hi_len    <= 0;
      end else begin
         if (spi_sclk && !prev_sclk) begin
            cap   <= {cap[14:0], spi_mosi};
            rises <= rises + 1;
         end
         if (spi_cs_n && !prev_cs) rx.push_back(cap);
         if (!spi_cs_n && prev_cs) begin
            rises       <= 0;
            last_hi_len <= hi_len;
         end
         hi_len    <= spi_cs_n ? hi_len + 1 : 0;
         prev_sclk <= spi_sclk;
         prev_cs   <= spi_cs_n;
         if (ack0) ack_cnt0 <= ack_cnt0 + 1;
         if (ack1) ack_cnt1 <= ack_cnt1 + 1;
      end
   end

   task automatic checkWord(input string name, input logic [15:0] required);
      logic [15:0] got;
      got = 16'bx;
      if (rx.size() > 0) got = rx.pop_front();
      checks++;
      if (got !== required) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, got, required, $time);
      end
   endtask

   task automatic waitAck(input bit which, input int limit, output int n);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!(which ? ack1 : ack0) && n < limit);
      checkBit(which ? "ack1_seen" : "ack0_seen", which ? ack1 : ack0, 1'b1);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int          n, acks_before;
      int          cs_low, rises20, last_rise, last_change, minsep;
      logic        psclk, pmosi;
      logic [15:0] cap20;

      #1 reset = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      checkBit("rst_cs_n", spi_cs_n, 1'b1);
      checkBit("rst_sclk", spi_sclk, 1'b0);
      checkBit("rst_mosi", spi_mosi, 1'b0);
      checkBit("rst_busy", busy, 1'b0);
      checkBit("rst_ack0", ack0, 1'b0);
      @(negedge clock);
      #2 reset = 1'b0;

      $display("[TB] single transfer");
      @(negedge clock);
      applyStimulus(1'b1, 16'hA5C3, 1'b0, 16'h0000);
      waitAck(1'b0, 400, n);
      req0 = 1'b0;
      checkOutput("single_latency", n, 145);
      checkWord("single_word", 16'hA5C3);
      checkOutput("single_no_ack1", ack_cnt1, 0);

      $display("[TB] tie and round-robin");
      repeat (3) @(negedge clock);
      #2 reset = 1'b1;
      @(negedge clock);
      #2 reset = 1'b0;
      @(negedge clock);
      applyStimulus(1'b1, 16'h1111, 1'b1, 16'h2222);
      waitAck(1'b0, 300, n);
      req0 = 1'b0;
      waitAck(1'b1, 300, n);
      req1 = 1'b0;
      checkWord("tie1_first", 16'h1111);
      checkWord("tie1_second", 16'h2222);
      repeat (3) @(negedge clock);
      applyStimulus(1'b1, 16'h1111, 1'b1, 16'h2222);
      waitAck(1'b0, 300, n);
      req0 = 1'b0;
      waitAck(1'b1, 300, n);
      req1 = 1'b0;
      checkWord("tie2_first", 16'h1111);
      checkWord("tie2_second", 16'h2222);
      repeat (3) @(negedge clock);
      applyStimulus(1'b0, 16'h1111, 1'b1, 16'h2222);
      repeat (50) @(negedge clock);
      req0 = 1'b1;
      waitAck(1'b1, 300, n);
      waitAck(1'b0, 300, n);
      req0 = 1'b0;
      waitAck(1'b1, 300, n);
      req1 = 1'b0;
      checkWord("rr_first", 16'h2222);
      checkWord("rr_second", 16'h1111);
      checkWord("rr_third", 16'h2222);

      $display("[TB] back-to-back");
      repeat (3) @(negedge clock);
      applyStimulus(1'b0, 16'h0000, 1'b1, 16'h3C3C);
      waitAck(1'b1, 300, n);
      data1 = 16'h00FF;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (spi_cs_n && n < 10);
      checkOutput("b2b_start", n, 2);
      waitAck(1'b1, 300, n);
      req1 = 1'b0;
      checkOutput("b2b_gap", last_hi_len, 2 * D + 2);
      checkWord("b2b_first", 16'h3C3C);
      checkWord("b2b_second", 16'h00FF);

      $display("[TB] reset mid-word");
      repeat (3) @(negedge clock);
      applyStimulus(1'b1, 16'hBEEF, 1'b0, 16'h0000);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (spi_cs_n && n < 20);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (rises < 7 && n < 300);
      checkOutput("mid_rises", rises, 7);
      checkBit("mid_cs_before", spi_cs_n, 1'b0);
      acks_before = ack_cnt0;
      #2 reset = 1'b1;
      #1;
      checkBit("mid_rst_cs_n", spi_cs_n, 1'b1);
      checkBit("mid_rst_sclk", spi_sclk, 1'b0);
      checkBit("mid_rst_mosi", spi_mosi, 1'b0);
      checkBit("mid_rst_busy", busy, 1'b0);
      repeat (2) @(negedge clock);
      #2 reset = 1'b0;
      waitAck(1'b0, 300, n);
      req0 = 1'b0;
      checkOutput("mid_after_latency", n, 145);
      @(negedge clock);
      checkOutput("mid_ack_count", ack_cnt0, acks_before + 1);
      checkWord("mid_clean_word", 16'hBEEF);

      $display("[TB] data stability");
      repeat (3) @(negedge clock);
      applyStimulus(1'b1, 16'h6A95, 1'b0, 16'h0000);
      n = 0;
      do begin
         @(negedge clock);
         n++;
         if (!ack0) data0 = 16'($urandom);
      end while (!ack0 && n < 300);
      checkBit("stab_ack0", ack0, 1'b1);
      req0 = 1'b0;
      checkWord("stab_word", 16'h6A95);

      $display("[TB] rate check CLK_DIV=20");
      repeat (3) @(negedge clock);
      r20a = 1'b1;
      d20a = 16'hC0DE;
      cs_low = 0; rises20 = 0; last_rise = 0; last_change = 0; minsep = 1000;
      psclk = 1'b0; pmosi = 1'b0; cap20 = '0; n = 0;
      do begin
         @(negedge clock);
         n++;
         if (!cs20) cs_low++;
         if (sclk20 && !psclk) begin
            rises20++;
            if (last_rise > 0) checkOutput("rate_sclk_period", n - last_rise, 40);
            if (last_change > 0 && n - last_change < minsep) minsep = n - last_change;
            last_rise = n;
            cap20 = {cap20[14:0], mosi20};
         end
         if (!cs20 && mosi20 !== pmosi) begin
            if (last_rise > 0 && n - last_rise < minsep) minsep = n - last_rise;
            last_change = n;
         end
         psclk = sclk20;
         pmosi = mosi20;
      end while (!a20a && n < 900);
      checkBit("rate_ack0", a20a, 1'b1);
      r20a = 1'b0;
      checkOutput("rate_latency", n, 721);
      checkOutput("rate_cs_low", cs_low, 680);
      checkOutput("rate_rises", rises20, 16);
      checkOutput("rate_word", {16'h0000, cap20}, 32'h0000C0DE);
      checkBit("rate_mosi_margin", minsep >= 20, 1'b1);

      repeat (5) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
